// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, gates register-file writes
// and exports a forwarding copy plus a retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_addr_lsb,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_mem_rdata,
  input  logic [ADDR_WIDTH-1:0] in_dst,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_w_addr,
  output logic [DATA_WIDTH-1:0] rf_d_in,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  misalign_err,
  output logic [CNT_WIDTH-1:0]  retire_cnt
);

  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic                  load_misal;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  misal_d;
  logic                  we_d;

  logic                  valid_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  always_comb begin
    byte_sel   = in_mem_rdata[{in_addr_lsb, 3'b000} +: 8];
    half_sel   = in_addr_lsb[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
    load_fmt   = in_mem_rdata;
    load_misal = 1'b0;
    case (in_load_type)
      3'b001: load_fmt = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b010: load_fmt = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b011: begin
        load_fmt   = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        load_misal = in_addr_lsb[0];
      end
      3'b100: begin
        load_fmt   = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        load_misal = in_addr_lsb[0];
      end
      // LW and the unused encodings 101-111
      default: begin
        load_fmt   = in_mem_rdata;
        load_misal = (in_addr_lsb != 2'b00);
      end
    endcase
    data_d  = in_mem_to_reg ? load_fmt : in_alu_result;
    misal_d = in_mem_to_reg & load_misal;
    we_d    = in_valid & in_reg_write & (in_dst != '0) & ~misal_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= in_valid;
      we_q    <= we_d;
      addr_q  <= in_dst;
      data_q  <= data_d;
      // A bubble carries no load, so it never reports a misalignment
      err_q   <= misal_d & in_valid;
      if (in_valid) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign rf_we        = we_q & valid_q;
  assign rf_w_addr    = addr_q;
  assign rf_d_in      = data_q;
  assign fwd_valid    = rf_we;
  assign fwd_addr     = rf_w_addr;
  assign fwd_data     = rf_d_in;
  assign misalign_err = err_q;
  assign retire_cnt   = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Table-driven bench for mem_wb_stage with an expected-result scoreboard;
// the counter is built 4 bits wide so wrap-around is reachable.
module tb_mem_wb_stage;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst, stall, flush;
  logic          in_valid, in_reg_write, in_mem_to_reg;
  logic [2:0]    in_load_type;
  logic [1:0]    in_addr_lsb;
  logic [DW-1:0] in_alu_result, in_mem_rdata;
  logic [AW-1:0] in_dst;
  logic          rf_we, fwd_valid, misalign_err;
  logic [AW-1:0] rf_w_addr, fwd_addr;
  logic [DW-1:0] rf_d_in, fwd_data;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_load_type(in_load_type), .in_addr_lsb(in_addr_lsb),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_dst(in_dst),
    .rf_we(rf_we), .rf_w_addr(rf_w_addr), .rf_d_in(rf_d_in),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic          valid, rw, m2r;
    logic [2:0]    lt;
    logic [1:0]    lsb;
    logic [DW-1:0] alu, rdata;
    logic [AW-1:0] dst;
    logic          e_we;
    logic [DW-1:0] e_data;
    logic          e_err;
  } vec_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  localparam logic [DW-1:0] RD = 32'h80FF_7F01;

  exp_t          sb[$];
  exp_t          last_e;
  vec_t          vecs[$];
  logic [CW-1:0] ecnt = '0;
  int            nvec = 0;
  int            nfail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      nvec++;
      nfail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".rf_we"},     32'(rf_we),        32'(e.we));
      cmp({tag, ".rf_w_addr"}, 32'(rf_w_addr),    32'(e.addr));
      cmp({tag, ".rf_d_in"},   rf_d_in,           e.data);
      cmp({tag, ".fwd_valid"}, 32'(fwd_valid),    32'(e.we));
      cmp({tag, ".fwd_addr"},  32'(fwd_addr),     32'(e.addr));
      cmp({tag, ".fwd_data"},  fwd_data,          e.data);
      cmp({tag, ".misalign"},  32'(misalign_err), 32'(e.err));
      cmp({tag, ".retire"},    32'(retire_cnt),   32'(e.cnt));
    end
  endtask

  task automatic step(input vec_t v, input logic st, input logic fl, input logic rs,
                      input string tag);
    exp_t e;
    rst           = rs;
    stall         = st;
    flush         = fl;
    in_valid      = v.valid;
    in_reg_write  = v.rw;
    in_mem_to_reg = v.m2r;
    in_load_type  = v.lt;
    in_addr_lsb   = v.lsb;
    in_alu_result = v.alu;
    in_mem_rdata  = v.rdata;
    in_dst        = v.dst;
    if (rs) begin
      ecnt = '0;
      e = '{1'b0, '0, '0, 1'b0, '0};
    end else if (fl) begin
      e = '{1'b0, '0, '0, 1'b0, ecnt};
    end else if (st) begin
      e = last_e;
    end else begin
      if (v.valid) ecnt = ecnt + 1'b1;
      e = '{v.e_we, v.dst, v.e_data, v.e_err, ecnt};
    end
    last_e = e;
    sb.push_back(e);
    check(tag);
  endtask

  function automatic vec_t alu_vec(input logic [AW-1:0] dst, input logic [DW-1:0] alu);
    alu_vec = '{1'b1, 1'b1, 1'b0, 3'b000, 2'b00, alu, 32'h0, dst, dst != '0, alu, 1'b0};
  endfunction

  initial begin
    vec_t v;
    // valid rw m2r lt lsb alu rdata dst | we data err
    vecs.push_back('{1, 1, 0, 3'b000, 2'd0, 32'h0000_1234, RD, 5'd7,  1, 32'h0000_1234, 0});
    vecs.push_back('{1, 1, 1, 3'b001, 2'd3, 32'h0,         RD, 5'd1,  1, 32'hFFFF_FF80, 0});
    vecs.push_back('{1, 1, 1, 3'b010, 2'd3, 32'h0,         RD, 5'd2,  1, 32'h0000_0080, 0});
    vecs.push_back('{1, 1, 1, 3'b011, 2'd2, 32'h0,         RD, 5'd3,  1, 32'hFFFF_80FF, 0});
    vecs.push_back('{1, 1, 1, 3'b100, 2'd0, 32'h0,         RD, 5'd4,  1, 32'h0000_7F01, 0});
    vecs.push_back('{1, 1, 1, 3'b000, 2'd0, 32'h0,         RD, 5'd5,  1, 32'h80FF_7F01, 0});
    vecs.push_back('{1, 1, 1, 3'b001, 2'd1, 32'h0,         RD, 5'd6,  1, 32'h0000_007F, 0});
    vecs.push_back('{1, 1, 1, 3'b011, 2'd0, 32'h0,         RD, 5'd8,  1, 32'h0000_7F01, 0});
    vecs.push_back('{1, 1, 1, 3'b100, 2'd2, 32'h0,         RD, 5'd10, 1, 32'h0000_80FF, 0});
    vecs.push_back('{1, 1, 1, 3'b111, 2'd0, 32'h0,         RD, 5'd11, 1, 32'h80FF_7F01, 0});
    vecs.push_back('{1, 1, 0, 3'b011, 2'd1, 32'hDEAD_BEEF, RD, 5'd12, 1, 32'hDEAD_BEEF, 0});
    vecs.push_back('{1, 1, 0, 3'b000, 2'd0, 32'h0000_0005, RD, 5'd0,  0, 32'h0000_0005, 0});
    vecs.push_back('{1, 1, 1, 3'b011, 2'd1, 32'h0,         RD, 5'd13, 0, 32'h0000_7F01, 1});
    vecs.push_back('{1, 1, 1, 3'b000, 2'd2, 32'h0,         RD, 5'd14, 0, 32'h80FF_7F01, 1});
    vecs.push_back('{1, 1, 1, 3'b100, 2'd3, 32'h0,         RD, 5'd15, 0, 32'h0000_80FF, 1});
    vecs.push_back('{1, 0, 0, 3'b000, 2'd0, 32'h0000_0009, RD, 5'd16, 0, 32'h0000_0009, 0});
    vecs.push_back('{0, 1, 0, 3'b000, 2'd0, 32'h0000_0001, RD, 5'd17, 0, 32'h0000_0001, 0});

    // Reset held two cycles with a live instruction on the inputs
    step(alu_vec(5'd5, 32'h1234), 1'b0, 1'b0, 1'b1, "reset0");
    step(alu_vec(5'd5, 32'h1234), 1'b0, 1'b0, 1'b1, "reset1");

    foreach (vecs[i]) step(vecs[i], 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));

    // Stall holds a captured write while the inputs keep changing
    step(alu_vec(5'd9, 32'hAA), 1'b0, 1'b0, 1'b0, "stall_cap");
    for (int i = 0; i < 3; i++) begin
      v = alu_vec(5'(20 + i), $urandom);
      step(v, 1'b1, 1'b0, 1'b0, $sformatf("stall%0d", i));
      cmp($sformatf("stall%0d.addr_const", i), 32'(rf_w_addr), 32'd9);
    end
    step(alu_vec(5'd21, 32'h55), 1'b1, 1'b1, 1'b0, "stall_flush");

    // A misaligned capture is cleared by flush; stall after flush keeps it clear
    step(vecs[13], 1'b0, 1'b0, 1'b0, "misal_cap");
    step(alu_vec(5'd22, 32'h66), 1'b0, 1'b1, 1'b0, "flush_only");
    step(alu_vec(5'd23, 32'h77), 1'b1, 1'b0, 1'b0, "stall_after_flush");

    // Reset wins over stall and flush
    step(alu_vec(5'd24, 32'h88), 1'b0, 1'b0, 1'b0, "pre_rst");
    step(alu_vec(5'd25, 32'h99), 1'b1, 1'b1, 1'b1, "rst_mid_stall");

    // Counter wrap on the 4-bit build
    for (int i = 1; i <= 17; i++) begin
      step(alu_vec(5'(i), 32'(i)), 1'b0, 1'b0, 1'b0, $sformatf("wrap%0d", i));
      if (i == 15) cmp("wrap_at15", 32'(retire_cnt), 32'd15);
      if (i == 16) cmp("wrap_at16", 32'(retire_cnt), 32'd0);
      if (i == 17) cmp("wrap_at17", 32'(retire_cnt), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and write-back formatter for the MIPS core. It sits directly upstream of the 32x32 register file and drives that file's write port (we, w_addr, d_in). Each cycle it captures the memory-stage result, applies load byte/halfword extraction and sign/zero extension, and suppresses writes to r0 and misaligned loads. It also exports a forwarding copy of the pending write and a retired-instruction counter.

Parameters:
DATA_WIDTH, 32, datapath and register width
ADDR_WIDTH, 5, register index width (32 registers)
CNT_WIDTH, 32, width of the retired-instruction counter

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  hold all stage state this cycle
flush  input  1  kill the stage contents this cycle; has priority over stall
in_valid  input  1  memory stage presents an instruction
in_reg_write  input  1  instruction writes a destination register
in_mem_to_reg  input  1  1 = result from memory read data, 0 = result from ALU
in_load_type  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101-111 treated as LW
in_addr_lsb  input  2  effective address bits [1:0] of the load
in_alu_result  input  DATA_WIDTH  ALU/address result
in_mem_rdata  input  DATA_WIDTH  aligned 32-bit word read from data memory
in_dst  input  ADDR_WIDTH  destination register index
rf_we  output  1  register file write enable
rf_w_addr  output  ADDR_WIDTH  register file write address
rf_d_in  output  DATA_WIDTH  register file write data
fwd_valid  output  1  pending write is forwardable (equals rf_we)
fwd_addr  output  ADDR_WIDTH  forwarding destination (equals rf_w_addr)
fwd_data  output  DATA_WIDTH  forwarding data (equals rf_d_in)
misalign_err  output  1  captured load was misaligned; write suppressed
retire_cnt  output  CNT_WIDTH  count of instructions retired through this stage

Behaviour:
- Reset: on a clk edge with rst=1, all outputs are 0: rf_we, rf_w_addr, rf_d_in, fwd_*, misalign_err, retire_cnt, and the internal valid bit. rst overrides flush and stall.
- Edge priority: rst > flush > stall > capture.
- flush=1: internal valid, rf_we, fwd_valid and misalign_err clear to 0. Address and data registers clear to 0. retire_cnt is unchanged.
- stall=1 (no flush): all registers hold, including rf_we. A repeated identical register-file write is permitted.
- Capture: one-cycle latency. Inputs sampled at edge N appear on the outputs after edge N. Formatting is combinational on the inputs, before the register.
- Result select: when in_mem_to_reg=0, the result is in_alu_result and the load type is ignored.
- Load formatting (little-endian):
  - Byte lane k = in_addr_lsb.
  - LB: sign-extends byte k. LBU: zero-extends byte k.
  - LH/LHU: halfword in_addr_lsb[1] (bits [15:0] or [31:16]), sign- or zero-extended.
- Misalignment: applies only when in_mem_to_reg=1.
  - LH/LHU with in_addr_lsb[0]=1, or LW with in_addr_lsb!=0, is misaligned.
  - Effect: misalign_err=1 and rf_we=0; rf_d_in still shows the formatted value.
- Write enable: rf_we = in_valid & in_reg_write & (in_dst!=0) & ~misaligned, all evaluated at capture. Writes to r0 never assert rf_we.
- rf_w_addr is always registered from in_dst, including when rf_we=0.
- Forwarding: the fwd_* outputs are wired equal to the rf_* outputs.
- retire_cnt:
  - Increments by 1 on each edge where the stage captures (no rst, flush or stall) with in_valid=1, regardless of in_reg_write or misalignment.
  - Wraps modulo 2^CNT_WIDTH from all-ones to 0.
- Reset mid-stall or mid-flush: reset wins and clears everything on that edge.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with in_valid=1, in_reg_write=1, in_dst=5 -> every output is 0 and retire_cnt=0.
2. ALU write: in_valid=1, in_reg_write=1, in_mem_to_reg=0, in_alu_result=0x0000_1234, in_dst=7 -> next cycle rf_we=1, rf_w_addr=7, rf_d_in=0x0000_1234, fwd_valid=1, retire_cnt=1.
3. Load extension: in_mem_rdata=0x80FF_7F01 with in_mem_to_reg=1. Expected rf_d_in per case:
   - LB, lsb=3 -> 0xFFFF_FF80
   - LBU, lsb=3 -> 0x0000_0080
   - LH, lsb=2 -> 0xFFFF_80FF
   - LHU, lsb=0 -> 0x0000_7F01
   - LW, lsb=0 -> 0x80FF_7F01
4. Write suppression cases:
   - in_dst=0 -> rf_we=0, retire_cnt still increments.
   - LH with lsb=1 -> rf_we=0, misalign_err=1.
   - LW with lsb=2 -> rf_we=0, misalign_err=1.
5. Stall and flush:
   - Capture dst=9/data=0xAA, then stall=1 for 3 cycles with changing inputs -> outputs hold 9/0xAA, rf_we=1, and retire_cnt does not change during the stall.
   - Then assert stall=1 and flush=1 together -> rf_we=0, misalign_err=0.
6. Counter wrap: with CNT_WIDTH=4, retire 17 consecutive valid instructions -> retire_cnt reads 15 after the 15th, 0 after the 16th, and 1 after the 17th.
